// File: rtl/key_expansion.sv
`default_nettype none
// ============================================================================
// Module      : key_expansion
// Description : One AES-128 key-schedule round; next round key is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module key_expansion (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] in,
    input  logic [31:0]  key,
    output logic [127:0] out
);

    // FIPS-197 forward S-box, entry 0x00 in the most significant byte
    localparam logic [2047:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        // Entry b lives at bit offset (255-b)*8, and 255-b is simply ~b
        sbox_lookup = C_SBOX[{~b, 3'b000} +: 8];
    endfunction

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot, w_sub, w_temp;
    logic [31:0]  w_w4, w_w5, w_w6, w_w7;
    logic [127:0] r_out;

    assign w_w0  = in[127:96];
    assign w_w1  = in[95:64];
    assign w_w2  = in[63:32];
    assign w_w3  = in[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    genvar i;
    generate
        for (i = 0; i < 4; i = i + 1) begin : g_sbox
            assign w_sub[8*i +: 8] = sbox_lookup(w_rot[8*i +: 8]);
        end
    endgenerate

    assign w_temp = w_sub ^ key;
    assign w_w4   = w_w0 ^ w_temp;
    assign w_w5   = w_w4 ^ w_w1;
    assign w_w6   = w_w5 ^ w_w2;
    assign w_w7   = w_w6 ^ w_w3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= {w_w4, w_w5, w_w6, w_w7};
        end
    end

    assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_key_expansion.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_expansion
// Description : Directed bench for key_expansion using FIPS-197 vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_expansion;

    logic         clk;
    logic         rst_n;
    logic [127:0] in;
    logic [31:0]  key;
    logic [127:0] out;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] C_K0  = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] C_K1  = 128'hA0FAFE1788542CB123A339392A6C7605;
    localparam logic [127:0] C_K2  = 128'hF2C295F27A96B9435935807A7359F67F;
    localparam logic [127:0] C_K9  = 128'hAC7766F319FADC2128D12941575C006E;
    localparam logic [127:0] C_K10 = 128'hD014F9A8C9EE2589E13F0CC8B6630CA6;

    key_expansion u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .key   (key),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in    = C_K0;
        key   = 32'h01000000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", out, 128'h0);

        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("round1", out, C_K1);

        // Inputs change mid-cycle; output must wait for the edge
        in  = C_K1;
        key = 32'h02000000;
        #2;
        check("no_comb_path", out, C_K1);
        step();
        check("round2", out, C_K2);

        in  = C_K9;
        key = 32'h36000000;
        step();
        check("round10", out, C_K10);

        in  = 128'h0;
        key = 32'h0;
        step();
        check("all_zero", out, {4{32'h63636363}});

        key = 32'h01000000;
        step();
        check("zero_rcon1", out, 128'h62636363626363636263636362636363);

        // Low Rcon bytes must take part in the XOR
        key = 32'hFFFFFFFF;
        step();
        check("rcon_all_bits", out, {4{32'h9C9C9C9C}});

        // Rotation direction plus S(53)=ED, S(FF)=16, S(00)=63, S(01)=7C
        in  = {96'h0, 32'h0153FF00};
        key = 32'h0;
        step();
        check("rot_sbox", out, 128'hED16637CED16637CED16637CEC459C7C);

        in  = C_K0;
        key = 32'h01000000;
        step();
        check("pipe_n", out, C_K1);
        in  = C_K1;
        key = 32'h02000000;
        step();
        check("pipe_n1", out, C_K2);
        #4;
        check("pipe_stable", out, C_K2);

        // Asynchronous reset between edges
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", out, 128'h0);
        step();
        check("reset_over_edge", out, 128'h0);

        in  = C_K9;
        key = 32'h36000000;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("after_release", out, C_K10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
